// File: rtl/qupls4_dram_oper_tracker_pkg.sv
// Shared types for the data-memory operation tracker: ROB index/mask types,
// per-slot bookkeeping record and the report record handed to memory-done.
package Qupls4_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int ROB_W       = $clog2(ROB_ENTRIES);
  localparam int AGE_W       = 3;

  typedef logic [ROB_W-1:0]       rob_ndx_t;
  typedef logic [ROB_ENTRIES-1:0] rob_bitmask_t;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'b00,
    SLOT_QUEUED = 2'b01,
    SLOT_SENT   = 2'b10,
    SLOT_DONE   = 2'b11
  } dram_slot_state_t;

  typedef struct packed {
    dram_slot_state_t   state;
    rob_ndx_t           id;
    logic               load;
    logic               store;
    logic               err;
    logic               stomped;
    logic [AGE_W-1:0]   age;
  } dram_slot_t;

  typedef struct packed {
    logic       v;
    logic [1:0] state;
    logic       load;
    logic       store;
    rob_ndx_t   id;
    logic       err;
  } dram_oper_t;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a,
                                                   input logic [AGE_W-1:0] lim);
    return (a >= lim) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/qupls4_dram_oper_tracker_rr.sv
// Round-robin one-hot picker: searches starting just after the last granted
// index and remembers the winner for the next search.
module qupls4_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] last;
  logic [IW-1:0] j;

  // N is a power of two, so IW-bit addition wraps the search naturally.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int k = 1; k <= N; k++) begin
      j = last + IW'(k);
      if (req[j] && !any) begin
        any     = 1'b1;
        gnt_idx = j;
        gnt[j]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= IW'(N - 1);
    else if (any)
      last <= gnt_idx;
  end

endmodule

// File: rtl/qupls4_dram_oper_tracker.sv
// Outstanding data-memory op tracker: slot allocation, oldest-first request
// issue, tag-matched ack completion, stomp handling and one report per cycle.
import Qupls4_pkg::*;

module qupls4_dram_oper_tracker #(
  parameter int NSLOT = 4,
  parameter int TW    = $clog2(NSLOT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_v,
  output logic         issue_rdy,
  input  rob_ndx_t     issue_id,
  input  logic         issue_load,
  input  logic         issue_store,
  output logic         mem_req_v,
  input  logic         mem_req_rdy,
  output logic [TW-1:0] mem_req_tag,
  output rob_ndx_t     mem_req_id,
  input  logic         mem_ack_v,
  input  logic [TW-1:0] mem_ack_tag,
  input  logic         mem_ack_err,
  input  rob_bitmask_t stomp,
  output dram_oper_t   dram_oper,
  output logic         dram_idv,
  output rob_ndx_t     dram_id,
  output logic         dram_stomp
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NSLOT - 1);

  dram_slot_t slot     [NSLOT];
  dram_slot_t slot_nxt [NSLOT];

  logic [NSLOT-1:0] done_vec;
  logic [NSLOT-1:0] rpt_gnt;
  logic [TW-1:0]    rpt_idx;
  logic             rpt_any;

  logic             issue_found;
  logic [TW-1:0]    issue_idx;
  logic             issue_fire;
  logic             req_found;
  logic [TW-1:0]    req_idx;
  logic [AGE_W-1:0] req_age;
  logic             req_fire;

  // Issue goes to the lowest free slot; request goes to the oldest queued slot.
  always_comb begin
    done_vec    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    req_found   = 1'b0;
    req_idx     = '0;
    req_age     = '0;
    for (int i = 0; i < NSLOT; i++) begin
      done_vec[i] = (slot[i].state == SLOT_DONE);
      if (slot[i].state == SLOT_IDLE && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = TW'(i);
      end
      if (slot[i].state == SLOT_QUEUED && (!req_found || slot[i].age > req_age)) begin
        req_found = 1'b1;
        req_idx   = TW'(i);
        req_age   = slot[i].age;
      end
    end
  end

  assign issue_rdy   = !rst && issue_found;
  assign issue_fire  = issue_v && issue_rdy;
  assign mem_req_v   = !rst && req_found;
  assign mem_req_tag = req_idx;
  assign mem_req_id  = slot[req_idx].id;
  assign req_fire    = mem_req_v && mem_req_rdy;

  qupls4_rr_pick #(.N(NSLOT), .IW(TW)) u_rpt_pick (
    .clk     (clk),
    .rst     (rst),
    .req     (done_vec),
    .gnt     (rpt_gnt),
    .gnt_idx (rpt_idx),
    .any     (rpt_any)
  );

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      slot_nxt[i] = slot[i];
      if (issue_fire && slot[i].state != SLOT_IDLE)
        slot_nxt[i].age = age_sat_inc(slot[i].age, AGE_MAX);
      case (slot[i].state)
        SLOT_IDLE: begin
          if (issue_fire && issue_idx == TW'(i))
            slot_nxt[i] = '{state: SLOT_QUEUED, id: issue_id, load: issue_load,
                            store: issue_store, err: 1'b0, stomped: 1'b0, age: '0};
        end
        SLOT_QUEUED: begin
          // A request accepted in the same cycle as its stomp still went out.
          if (req_fire && req_idx == TW'(i)) begin
            slot_nxt[i].state   = slot[i].load ? SLOT_SENT : SLOT_DONE;
            slot_nxt[i].stomped = stomp[slot[i].id];
          end else if (stomp[slot[i].id]) begin
            slot_nxt[i] = '0;
          end
        end
        SLOT_SENT: begin
          if (stomp[slot[i].id])
            slot_nxt[i].stomped = 1'b1;
          if (mem_ack_v && mem_ack_tag == TW'(i)) begin
            slot_nxt[i].state = SLOT_DONE;
            slot_nxt[i].err   = mem_ack_err;
          end
        end
        SLOT_DONE: begin
          if (stomp[slot[i].id])
            slot_nxt[i].stomped = 1'b1;
          if (rpt_gnt[i])
            slot_nxt[i] = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++)
        slot[i] <= '0;
      dram_idv   <= 1'b0;
      dram_id    <= '0;
      dram_stomp <= 1'b0;
      dram_oper  <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++)
        slot[i] <= slot_nxt[i];
      if (rpt_any) begin
        dram_idv   <= 1'b1;
        dram_id    <= slot[rpt_idx].id;
        dram_stomp <= slot[rpt_idx].stomped;
        dram_oper  <= '{v: 1'b1, state: SLOT_DONE, load: slot[rpt_idx].load,
                        store: slot[rpt_idx].store, id: slot[rpt_idx].id,
                        err: slot[rpt_idx].err};
      end else begin
        dram_idv   <= 1'b0;
        dram_id    <= '0;
        dram_stomp <= 1'b0;
        dram_oper  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qupls4_dram_oper_tracker.sv
// Directed bench for the DRAM op tracker: a per-cycle vector table plus
// hand-written stomp, same-cycle stomp/send and mid-flight reset sequences.
module tb_qupls4_dram_oper_tracker;
  import Qupls4_pkg::*;

  logic         clk;
  logic         rst;
  logic         issue_v;
  logic         issue_rdy;
  rob_ndx_t     issue_id;
  logic         issue_load;
  logic         issue_store;
  logic         mem_req_v;
  logic         mem_req_rdy;
  logic [1:0]   mem_req_tag;
  rob_ndx_t     mem_req_id;
  logic         mem_ack_v;
  logic [1:0]   mem_ack_tag;
  logic         mem_ack_err;
  rob_bitmask_t stomp;
  dram_oper_t   dram_oper;
  logic         dram_idv;
  rob_ndx_t     dram_id;
  logic         dram_stomp;

  qupls4_dram_oper_tracker #(.NSLOT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_v     (issue_v),
    .issue_rdy   (issue_rdy),
    .issue_id    (issue_id),
    .issue_load  (issue_load),
    .issue_store (issue_store),
    .mem_req_v   (mem_req_v),
    .mem_req_rdy (mem_req_rdy),
    .mem_req_tag (mem_req_tag),
    .mem_req_id  (mem_req_id),
    .mem_ack_v   (mem_ack_v),
    .mem_ack_tag (mem_ack_tag),
    .mem_ack_err (mem_ack_err),
    .stomp       (stomp),
    .dram_oper   (dram_oper),
    .dram_idv    (dram_idv),
    .dram_id     (dram_id),
    .dram_stomp  (dram_stomp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int iv, iid, ild, ist, rrdy, av, atag, aerr;
    int e_irdy, e_rv, e_rtag, e_rid;
    int e_idv, e_id, e_ld, e_st, e_err, e_stmp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    issue_v = 0; issue_id = '0; issue_load = 0; issue_store = 0;
    mem_req_rdy = 0; mem_ack_v = 0; mem_ack_tag = '0; mem_ack_err = 0;
    stomp = '0;
  endtask

  task automatic wait_idv(input string name, input int budget);
    int n;
    n = 0;
    while (dram_idv !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_report_seen"}, int'(dram_idv === 1'b1), 1);
  endtask

  function automatic int exp_oper(input vec_t v);
    dram_oper_t o;
    o = '0;
    if (v.e_idv != 0) begin
      o.v = 1'b1; o.state = 2'b11; o.load = v.e_ld[0]; o.store = v.e_st[0];
      o.id = rob_ndx_t'(v.e_id); o.err = v.e_err[0];
    end
    return int'(o);
  endfunction

  initial begin
    // iv iid ild ist rrdy av atag aerr | irdy rv rtag rid | idv id ld st err stmp
    vecs.push_back('{1,5,1,0,1,0,0,0, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,1,0,5, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,7,0,1,1,0,0,0, 1,0,0,0, 1,5,1,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 1,1,0,7, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,1,1,0,0,0,0,0, 1,0,0,0, 1,7,0,1,0,0});
    vecs.push_back('{1,2,1,0,0,0,0,0, 1,1,0,1, 0,0,0,0,0,0});
    vecs.push_back('{1,3,1,0,0,0,0,0, 1,1,0,1, 0,0,0,0,0,0});
    vecs.push_back('{1,4,1,0,0,0,0,0, 1,1,0,1, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 0,1,0,1, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 0,1,1,2, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 0,1,2,3, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,1,0,0,0, 0,1,3,4, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,2,0, 0,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,1,0, 0,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 1,3,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,0,0, 1,0,0,0, 1,2,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,1,3,1, 1,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 1,1,1,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 1,4,1,0,1,0});
    vecs.push_back('{0,0,0,0,0,0,0,0, 1,0,0,0, 0,0,0,0,0,0});

    clear_in();
    rst = 1;
    repeat (3) step();
    #1;
    chk("rst_issue_rdy", int'(issue_rdy), 0);
    chk("rst_req_v", int'(mem_req_v), 0);
    chk("rst_idv", int'(dram_idv), 0);
    chk("rst_stomp", int'(dram_stomp), 0);
    chk("rst_oper", int'(dram_oper), 0);
    chk("rst_id", int'(dram_id), 0);
    @(negedge clk);
    rst = 0;

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      v = vecs[k];
      issue_v = v.iv[0]; issue_id = rob_ndx_t'(v.iid); issue_load = v.ild[0];
      issue_store = v.ist[0]; mem_req_rdy = v.rrdy[0]; mem_ack_v = v.av[0];
      mem_ack_tag = 2'(v.atag); mem_ack_err = v.aerr[0];
      #1;
      chk($sformatf("v%0d_issue_rdy", k), int'(issue_rdy), v.e_irdy);
      chk($sformatf("v%0d_req_v", k), int'(mem_req_v), v.e_rv);
      if (v.e_rv != 0) begin
        chk($sformatf("v%0d_req_tag", k), int'(mem_req_tag), v.e_rtag);
        chk($sformatf("v%0d_req_id", k), int'(mem_req_id), v.e_rid);
      end
      chk($sformatf("v%0d_idv", k), int'(dram_idv), v.e_idv);
      chk($sformatf("v%0d_id", k), int'(dram_id), v.e_idv != 0 ? v.e_id : 0);
      chk($sformatf("v%0d_stomp", k), int'(dram_stomp), v.e_stmp);
      chk($sformatf("v%0d_oper", k), int'(dram_oper), exp_oper(v));
      step();
    end
    clear_in();

    // Load id 9 stomped while SENT: still waits for its ack, reported as stomped.
    issue_v = 1; issue_id = 4'd9; issue_load = 1;
    step();
    clear_in();
    mem_req_rdy = 1;
    #1;
    chk("s9_req_v", int'(mem_req_v), 1);
    chk("s9_req_id", int'(mem_req_id), 9);
    step();
    clear_in();
    stomp[9] = 1'b1;
    step();
    clear_in();
    step();
    mem_ack_v = 1; mem_ack_tag = 2'd0;
    step();
    clear_in();
    chk("s9_no_early_report", int'(dram_idv), 0);
    wait_idv("s9", 4);
    chk("s9_id", int'(dram_id), 9);
    chk("s9_dram_stomp", int'(dram_stomp), 1);
    chk("s9_state", int'(dram_oper.state), 3);
    step();
    chk("s9_pulse_one_cycle", int'(dram_idv), 0);

    // Load id 3 stomped while QUEUED: dropped, never requested or reported.
    issue_v = 1; issue_id = 4'd3; issue_load = 1;
    step();
    clear_in();
    stomp[3] = 1'b1;
    step();
    clear_in();
    #1;
    chk("s3_req_v_after", int'(mem_req_v), 0);
    chk("s3_issue_rdy", int'(issue_rdy), 1);
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        step();
        if (dram_idv === 1'b1) seen++;
      end
      chk("s3_no_report", seen, 0);
    end
    issue_v = 1; issue_id = 4'd6; issue_load = 1;
    step();
    clear_in();
    #1;
    chk("s3_slot_reused_tag", int'(mem_req_tag), 0);
    chk("s3_slot_reused_id", int'(mem_req_id), 6);

    // Stomp and send in the same cycle: request counts, op reported stomped.
    mem_req_rdy = 1; stomp[6] = 1'b1;
    #1;
    chk("s6_req_v", int'(mem_req_v), 1);
    step();
    clear_in();
    #1;
    chk("s6_req_v_after", int'(mem_req_v), 0);
    mem_ack_v = 1; mem_ack_tag = 2'd0;
    step();
    clear_in();
    wait_idv("s6", 4);
    chk("s6_id", int'(dram_id), 6);
    chk("s6_dram_stomp", int'(dram_stomp), 1);
    step();

    // Reset with one op in flight and one queued; a late ack must be ignored.
    issue_v = 1; issue_id = 4'd10; issue_load = 1;
    step();
    clear_in();
    mem_req_rdy = 1;
    step();
    clear_in();
    issue_v = 1; issue_id = 4'd11; issue_load = 1;
    step();
    clear_in();
    rst = 1; mem_ack_v = 1; mem_ack_tag = 2'd0;
    #1;
    chk("mrst_issue_rdy", int'(issue_rdy), 0);
    chk("mrst_req_v", int'(mem_req_v), 0);
    step();
    rst = 0;
    #1;
    chk("mrst_issue_rdy_after", int'(issue_rdy), 1);
    chk("mrst_req_v_after", int'(mem_req_v), 0);
    chk("mrst_idv", int'(dram_idv), 0);
    step();
    clear_in();
    begin
      int seen;
      seen = 0;
      repeat (4) begin
        step();
        if (dram_idv === 1'b1) seen++;
      end
      chk("mrst_late_ack_ignored", seen, 0);
    end
    chk("mrst_oper", int'(dram_oper), 0);
    chk("mrst_id", int'(dram_id), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
